sqi_sram_model: RTL

Synthesizable single-clock model of the 23LC1024-style serial SRAM that sits on the far side of the video RAM controller's SIO bus. It oversamples `sram_sck` and `sram_cs_n` with the system clock, decodes SPI and SQI READ/WRITE/EQIO/RSTIO transactions, and drives read data back onto the SIO lines. It lets simulation and formal benches close the loop around the VRAM controller and the video signal generator without an external memory.

---
 rtl/sqi_sram_pkg.sv | 22 ++
 rtl/sqi_sram_edge_detect.sv | 21 ++
 rtl/sqi_sram_model.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sqi_sram_pkg.sv
// Shared constants and state encoding for the serial SRAM model.
// Command opcodes follow the 23LC1024 instruction set.
package sqi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_EQIO  = 8'h38;
  localparam logic [7:0] CMD_RSTIO = 8'hFF;

  localparam int unsigned ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/sqi_sram_edge_detect.sv
// Oversamples the serial clock and flags its rising and falling edges.
// Each sck level must last at least one clk.
module sqi_sram_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  output logic rise,
  output logic fall
);

  logic sck_q;

  always_ff @(posedge clk) begin
    if (reset) sck_q <= 1'b0;
    else       sck_q <= sck;
  end

  assign rise = sck & ~sck_q;
  assign fall = ~sck & sck_q;

endmodule

// File: rtl/sqi_sram_model.sv
// 23LC1024-style SPI/SQI serial SRAM model on the system clock.
// Define SQI_SRAM_PROTOCOL_CHECK_EN to compile in bus protocol checks.
module sqi_sram_model
  import sqi_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sram_cs_n,
  input  logic       sram_sck,
  input  logic [3:0] sram_sio_i,
  output logic [3:0] sram_sio_o,
  output logic [3:0] sram_sio_oe,
  output logic       sqi_mode
);

  state_t state, state_d, cur;
  logic rise, fall;
  logic [4:0] cnt, cnt_in, step;
  logic [23:0] sr, sr_in;
  logic [ADDR_WIDTH-1:0] addr;
  logic is_read;
  logic [7:0] rd_sr, rd_byte;
  logic [3:0] rd_cnt, rd_cnt_in, rd_step;
  logic shift_en, field_end, cmd_end, addr_end, wr_end;
  logic set_sqi, clr_sqi;
  logic unused_ok;
  logic [7:0] mem [2**ADDR_WIDTH];

  sqi_sram_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .sck   (sram_sck),
    .rise  (rise),
    .fall  (fall)
  );

  assign unused_ok = sr[23];

  always_comb begin
    step      = sqi_mode ? 5'd4 : 5'd1;
    sr_in     = sqi_mode ? {sr[19:0], sram_sio_i}
                         : {sr[22:0], sram_sio_i[0]};
    cnt_in    = cnt + step;
    rd_step   = sqi_mode ? 4'd4 : 4'd1;
    rd_cnt_in = rd_cnt + rd_step;
    rd_byte   = (rd_cnt == 4'd0) ? mem[addr] : rd_sr;
    // IDLE behaves as CMD so a bit on the first rise is not lost
    cur       = (state == ST_IDLE) ? ST_CMD : state;
    state_d   = sram_cs_n ? ST_IDLE : cur;
    shift_en  = 1'b0;
    field_end = 1'b0;
    cmd_end   = 1'b0;
    addr_end  = 1'b0;
    wr_end    = 1'b0;
    set_sqi   = 1'b0;
    clr_sqi   = 1'b0;
    if (!sram_cs_n && rise) begin
      unique case (cur)
        ST_CMD: begin
          shift_en = 1'b1;
          if (cnt_in == 5'd8) begin
            field_end = 1'b1;
            cmd_end   = 1'b1;
            state_d   = ST_IGNORE;
            unique case (1'b1)
              sr_in[7:0] == CMD_READ:  state_d = ST_ADDR;
              sr_in[7:0] == CMD_WRITE: state_d = ST_ADDR;
              sr_in[7:0] == CMD_EQIO:  set_sqi = 1'b1;
              sr_in[7:0] == CMD_RSTIO: clr_sqi = sqi_mode;
              default: ;
            endcase
          end
        end
        ST_ADDR: begin
          shift_en = 1'b1;
          if (cnt_in == 5'(ADDR_BITS)) begin
            field_end = 1'b1;
            addr_end  = 1'b1;
            if (!is_read)     state_d = ST_WR_DATA;
            else if (sqi_mode) state_d = ST_DUMMY;
            else              state_d = ST_RD_DATA;
          end
        end
        ST_DUMMY: begin
          shift_en = 1'b1;
          if (cnt_in == 5'd8) begin
            field_end = 1'b1;
            state_d   = ST_RD_DATA;
          end
        end
        ST_WR_DATA: begin
          shift_en = 1'b1;
          if (cnt_in == 5'd8) begin
            field_end = 1'b1;
            wr_end    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sqi_mode    <= 1'b0;
      is_read     <= 1'b0;
      cnt         <= '0;
      sr          <= '0;
      addr        <= '0;
      rd_sr       <= '0;
      rd_cnt      <= '0;
      sram_sio_o  <= '0;
      sram_sio_oe <= '0;
    end else if (sram_cs_n) begin
      cnt         <= '0;
      rd_cnt      <= '0;
      sram_sio_o  <= '0;
      sram_sio_oe <= '0;
    end else begin
      if (shift_en) begin
        sr  <= sr_in;
        cnt <= field_end ? 5'd0 : cnt_in;
      end
      if (cmd_end)  is_read  <= (sr_in[7:0] == CMD_READ);
      if (set_sqi)  sqi_mode <= 1'b1;
      if (clr_sqi)  sqi_mode <= 1'b0;
      if (addr_end) addr     <= sr_in[ADDR_WIDTH-1:0];
      if (wr_end)   addr     <= addr + 1'b1;
      if (fall && state == ST_RD_DATA) begin
        sram_sio_oe <= sqi_mode ? 4'hF : 4'h2;
        sram_sio_o  <= sqi_mode ? rd_byte[7:4]
                                : {2'b00, rd_byte[7], 1'b0};
        rd_sr       <= sqi_mode ? {rd_byte[3:0], 4'h0}
                                : {rd_byte[6:0], 1'b0};
        rd_cnt      <= (rd_cnt_in == 4'd8) ? 4'd0 : rd_cnt_in;
        // a byte is fetched on its first fall, so bump addr then
        if (rd_cnt == 4'd0) addr <= addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_end) mem[addr] <= sr_in[7:0];
  end

`ifdef SQI_SRAM_PROTOCOL_CHECK_EN
  logic cs_q;

  always_ff @(posedge clk) begin
    cs_q <= reset ? 1'b1 : sram_cs_n;
    if (reset) begin
      assert (!(rise || fall))
        else $error("sck edge during reset");
    end else begin
      assert (sram_sio_oe == 4'h0 || state == ST_RD_DATA)
        else $error("model drives sio outside read data");
      if (cs_q && !sram_cs_n)
        assert (!sram_sck) else $error("sck high at cs fall");
    end
  end
`else
`endif

endmodule
